// File: rtl/decode_pkg.sv
// +--------------------------------------------------------------------------+
// | decode_pkg: shared geometry, opcode map and decoded bundle for decode.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package decode_pkg;

  localparam int DEC_INSTR_W      = 32;
  localparam int DEC_FIELD_W      = 8;
  localparam int DEC_REG_ADDR_W   = 3;
  localparam int DEC_OFFSET_W     = 32;
  localparam int DEC_OFFSET_SHIFT = 2;
  localparam int DEC_PC_W         = 32;

  // Bit position of the low end of each byte field in the instruction word.
  localparam int OPCODE_LSB = 3 * DEC_FIELD_W;
  localparam int DEST_LSB   = 2 * DEC_FIELD_W;
  localparam int SRC1_LSB   = 1 * DEC_FIELD_W;
  localparam int SRC2_LSB   = 0;

  localparam logic [DEC_FIELD_W-1:0] OP_LOADI = 8'd0;
  localparam logic [DEC_FIELD_W-1:0] OP_MOV   = 8'd1;
  localparam logic [DEC_FIELD_W-1:0] OP_ADD   = 8'd2;
  localparam logic [DEC_FIELD_W-1:0] OP_SUB   = 8'd3;
  localparam logic [DEC_FIELD_W-1:0] OP_AND   = 8'd4;
  localparam logic [DEC_FIELD_W-1:0] OP_OR    = 8'd5;
  localparam logic [DEC_FIELD_W-1:0] OP_J     = 8'd6;
  localparam logic [DEC_FIELD_W-1:0] OP_BEQ   = 8'd7;
  localparam logic [DEC_FIELD_W-1:0] OP_BNE   = 8'd8;
  localparam logic [DEC_FIELD_W-1:0] OP_SLL   = 8'd9;
  localparam logic [DEC_FIELD_W-1:0] OP_LWD   = 8'd10;
  localparam logic [DEC_FIELD_W-1:0] OP_SWD   = 8'd11;

  localparam int DEC_NUM_OPCODES = int'(OP_SWD) + 1;

  typedef struct packed {
    logic [DEC_FIELD_W-1:0]    opcode;
    logic [DEC_REG_ADDR_W-1:0] writereg;
    logic [DEC_REG_ADDR_W-1:0] readreg1;
    logic [DEC_REG_ADDR_W-1:0] readreg2;
    logic [DEC_FIELD_W-1:0]    immediate;
    logic [DEC_OFFSET_W-1:0]   offset;
    logic [DEC_PC_W-1:0]       pc;
    logic                      illegal;
  } decoded_t;

endpackage

`default_nettype wire

// File: rtl/decode_fields.sv
// +--------------------------------------------------------------------------+
// | decode_fields: combinational field split, offset sign-extend, illegal.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module decode_fields
  import decode_pkg::*;
#(
  parameter int INSTR_W      = DEC_INSTR_W,
  parameter int FIELD_W      = DEC_FIELD_W,
  parameter int REG_ADDR_W   = DEC_REG_ADDR_W,
  parameter int OFFSET_W     = DEC_OFFSET_W,
  parameter int OFFSET_SHIFT = DEC_OFFSET_SHIFT,
  parameter int NUM_OPCODES  = DEC_NUM_OPCODES,
  parameter int PC_W         = DEC_PC_W
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output decoded_t           o_fields
);

  localparam logic [FIELD_W:0] OPCODE_LIMIT = (FIELD_W+1)'(NUM_OPCODES);

  logic [FIELD_W-1:0]  opcode;
  logic [FIELD_W-1:0]  offset_field;
  logic [OFFSET_W-1:0] offset_ext;

  always_comb begin
    opcode       = i_instr[OPCODE_LSB +: FIELD_W];
    offset_field = i_instr[DEST_LSB +: FIELD_W];
    offset_ext   = {{(OFFSET_W-FIELD_W){offset_field[FIELD_W-1]}}, offset_field};

    o_fields           = '0;
    o_fields.opcode    = opcode;
    o_fields.writereg  = i_instr[DEST_LSB +: REG_ADDR_W];
    o_fields.readreg1  = i_instr[SRC1_LSB +: REG_ADDR_W];
    o_fields.readreg2  = i_instr[SRC2_LSB +: REG_ADDR_W];
    o_fields.immediate = i_instr[SRC2_LSB +: FIELD_W];
    o_fields.offset    = offset_ext << OFFSET_SHIFT;
    o_fields.pc        = i_pc;
    // Illegal words still flow through; the consumer owns the trap.
    o_fields.illegal   = ({1'b0, opcode} >= OPCODE_LIMIT);
  end

endmodule

`default_nettype wire

// File: rtl/instruction_decode_stage.sv
// +--------------------------------------------------------------------------+
// | instruction_decode_stage: registered decode with valid/ready skid buffer. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module instruction_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W      = DEC_INSTR_W,
  parameter int FIELD_W      = DEC_FIELD_W,
  parameter int REG_ADDR_W   = DEC_REG_ADDR_W,
  parameter int OFFSET_W     = DEC_OFFSET_W,
  parameter int OFFSET_SHIFT = DEC_OFFSET_SHIFT,
  parameter int NUM_OPCODES  = DEC_NUM_OPCODES,
  parameter int PC_W         = DEC_PC_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [INSTR_W-1:0]    INSTRUCTION,
  input  logic [PC_W-1:0]       IN_PC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [FIELD_W-1:0]    OPCODE,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [FIELD_W-1:0]    IMMEDIATE,
  output logic [OFFSET_W-1:0]   OFFSET,
  output logic [PC_W-1:0]       OUT_PC,
  output logic                  ILLEGAL
);

  decoded_t main_q, main_d;
  decoded_t skid_q, skid_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  decoded_t decoded;
  logic     in_xfer;
  logic     out_xfer;

  decode_fields #(
    .INSTR_W      (INSTR_W),
    .FIELD_W      (FIELD_W),
    .REG_ADDR_W   (REG_ADDR_W),
    .OFFSET_W     (OFFSET_W),
    .OFFSET_SHIFT (OFFSET_SHIFT),
    .NUM_OPCODES  (NUM_OPCODES),
    .PC_W         (PC_W)
  ) u_decode_fields (
    .i_instr  (INSTRUCTION),
    .i_pc     (IN_PC),
    .o_fields (decoded)
  );

  // Ready depends only on the skid flop, so no combinational path from OUT_READY.
  assign IN_READY = ~skid_valid_q & ~RESET;
  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = main_valid_q & OUT_READY;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (FLUSH) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_xfer) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      if (in_xfer) begin
        if (!main_valid_q || out_xfer) begin
          main_d       = decoded;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = decoded;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign OUT_VALID = main_valid_q;
  assign OPCODE    = main_q.opcode;
  assign WRITEREG  = main_q.writereg;
  assign READREG1  = main_q.readreg1;
  assign READREG2  = main_q.readreg2;
  assign IMMEDIATE = main_q.immediate;
  assign OFFSET    = main_q.offset;
  assign OUT_PC    = main_q.pc;
  assign ILLEGAL   = main_q.illegal;

endmodule

`default_nettype wire
